// File: rtl/aes_dec_keygen_if.sv
// Key-scheduler bus between the decryption control and aes_dec_keygen.
//   master: drives cipher_key / key_load / next_key, receives round keys.
//   slave : the key scheduler (aes_dec_keygen).
interface aes_dec_keygen_if;
   logic [127:0] cipher_key;
   logic         key_load;
   logic         next_key;
   logic [127:0] round_key;
   logic [3:0]   round_number;
   logic         key_ready;
   logic         busy;

   modport master (
      output cipher_key, key_load, next_key,
      input  round_key, round_number, key_ready, busy
   );

   modport slave (
      input  cipher_key, key_load, next_key,
      output round_key, round_number, key_ready, busy
   );
endinterface

// File: rtl/aes_dec_keygen.sv
// AES-128 decryption key scheduler: expands the cipher key forward to the
// round-10 key (one round per cycle), then walks the inverse key schedule to
// hand out round keys 10 down to 0, one per next_key request, wrapping back
// to the saved round-10 key after round 0.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   kif       - aes_dec_keygen_if.slave: cipher_key/key_load/next_key in,
//               round_key/round_number/key_ready/busy out
// Optional macro AES_EQUIV_INV_KEY_EN: rounds 1..9 are presented through
// InvMixColumns for the equivalent inverse cipher.

// AES forward S-box, table lookup.
module aes_dec_keygen_sbox (
   input  logic [7:0] din,
   output logic [7:0] dout
);
   localparam logic [2047:0] SBOX_TABLE = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };
   // Entry 0 sits in the top byte, so index from the top with ~din.
   assign dout = SBOX_TABLE[{~din, 3'b000} +: 8];
endmodule

module aes_dec_keygen (
   input logic             clk,
   input logic             rst,
   aes_dec_keygen_if.slave kif
);
   localparam int unsigned KEY_W  = 128;
   localparam int unsigned WORD_W = 32;
   localparam int unsigned RND_W  = 4;
   localparam logic [RND_W-1:0] LAST_RND = RND_W'(10);

   typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

   state_t             state_q, state_d;
   logic [KEY_W-1:0]   work_q, work_d;
   logic [KEY_W-1:0]   last_q, last_d;
   logic [RND_W-1:0]   rnd_q, rnd_d;

   logic [WORD_W-1:0]  v0, v1, v2, v3;
   logic [WORD_W-1:0]  core_word, sb_in, sb_out, t;
   logic [RND_W-1:0]   rcon_idx;
   logic [7:0]         rcon;
   logic [KEY_W-1:0]   fwd_key, inv_key;

   function automatic logic [7:0] rcon_of(input logic [RND_W-1:0] r);
      case (r)
         4'd1:    rcon_of = 8'h01;
         4'd2:    rcon_of = 8'h02;
         4'd3:    rcon_of = 8'h04;
         4'd4:    rcon_of = 8'h08;
         4'd5:    rcon_of = 8'h10;
         4'd6:    rcon_of = 8'h20;
         4'd7:    rcon_of = 8'h40;
         4'd8:    rcon_of = 8'h80;
         4'd9:    rcon_of = 8'h1b;
         4'd10:   rcon_of = 8'h36;
         default: rcon_of = 8'h00;
      endcase
   endfunction

   assign {v0, v1, v2, v3} = work_q;

   // Shared S-box path: forward uses w3 of the current key, inverse uses the
   // recovered older w3 (= v3 ^ v2); rcon index follows the same split.
   always_comb begin
      core_word = v3;
      rcon_idx  = RND_W'(rnd_q + RND_W'(1));
      if (state_q == READY) begin
         core_word = v3 ^ v2;
         rcon_idx  = rnd_q;
      end
   end

   assign sb_in = {core_word[23:0], core_word[31:24]};

   for (genvar i = 0; i < 4; i++) begin : g_sbox
      aes_dec_keygen_sbox u_sbox (
         .din  (sb_in[8*i +: 8]),
         .dout (sb_out[8*i +: 8])
      );
   end

   assign rcon = rcon_of(rcon_idx);
   assign t    = sb_out ^ {rcon, 24'h0};

   always_comb begin
      logic [WORD_W-1:0] f0, f1, f2, f3;
      f0      = v0 ^ t;
      f1      = v1 ^ f0;
      f2      = v2 ^ f1;
      f3      = v3 ^ f2;
      fwd_key = {f0, f1, f2, f3};
      inv_key = {v0 ^ t, v1 ^ v0, v2 ^ v1, v3 ^ v2};
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         last_q  <= '0;
         rnd_q   <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         last_q  <= last_d;
         rnd_q   <= rnd_d;
      end
   end

   // Next state; key_load overrides everything, including next_key.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      last_d  = last_q;
      rnd_d   = rnd_q;
      if (kif.key_load) begin
         work_d  = kif.cipher_key;
         rnd_d   = '0;
         state_d = EXPAND;
      end else begin
         case (state_q)
            EXPAND: begin
               work_d = fwd_key;
               rnd_d  = RND_W'(rnd_q + RND_W'(1));
               if (rnd_q == LAST_RND - RND_W'(1)) begin
                  last_d  = fwd_key;
                  state_d = READY;
               end
            end
            READY: begin
               if (kif.next_key) begin
                  if (rnd_q != '0) begin
                     work_d = inv_key;
                     rnd_d  = RND_W'(rnd_q - RND_W'(1));
                  end else begin
                     work_d = last_q;
                     rnd_d  = LAST_RND;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign kif.round_number = rnd_q;
   assign kif.key_ready    = (state_q == READY);
   assign kif.busy         = (state_q == EXPAND);

`ifdef AES_EQUIV_INV_KEY_EN
   function automatic logic [7:0] xt(input logic [7:0] b);
      xt = {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
      logic [7:0] a [4];
      logic [7:0] m9 [4], m11 [4], m13 [4], m14 [4];
      for (int i = 0; i < 4; i++) begin
         logic [7:0] m2, m4, m8;
         a[i]   = c[31-8*i -: 8];
         m2     = xt(a[i]);
         m4     = xt(m2);
         m8     = xt(m4);
         m9[i]  = m8 ^ a[i];
         m11[i] = m8 ^ m2 ^ a[i];
         m13[i] = m8 ^ m4 ^ a[i];
         m14[i] = m8 ^ m4 ^ m2;
      end
      inv_mix_col = {m14[0] ^ m11[1] ^ m13[2] ^ m9[3],
                     m9[0]  ^ m14[1] ^ m11[2] ^ m13[3],
                     m13[0] ^ m9[1]  ^ m14[2] ^ m11[3],
                     m11[0] ^ m13[1] ^ m9[2]  ^ m14[3]};
   endfunction

   // Middle rounds go through InvMixColumns; first/last stay raw.
   assign kif.round_key = (rnd_q != '0 && rnd_q != LAST_RND) ?
                          {inv_mix_col(v0), inv_mix_col(v1), inv_mix_col(v2), inv_mix_col(v3)} :
                          work_q;
`else
   assign kif.round_key = work_q;
`endif

endmodule

// File: tb/tb_aes_dec_keygen.sv
// Self-checking bench for aes_dec_keygen: reference model derives the S-box
// from GF(2^8) inversion plus the affine map and expands keys with the
// textbook word recurrence.
module tb_aes_dec_keygen;
   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   aes_dec_keygen_if kif ();

   aes_dec_keygen dut (
      .clk (clk),
      .rst (rst),
      .kif (kif)
   );

   logic [7:0]   sbox_tab [256];
   logic [127:0] raw_keys [11];
   logic [127:0] exp_keys [11];

   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      logic       hi;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b  = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   task automatic build_sbox();
      for (int x = 0; x < 256; x++) begin
         logic [7:0] inv, s;
         inv = 8'h00;
         if (x != 0)
            for (int y = 1; y < 256; y++)
               if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
             {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
         sbox_tab[x] = s;
      end
   endtask

   function automatic logic [127:0] inv_mix_model(input logic [127:0] s);
      logic [127:0] r;
      logic [7:0]   coef [4];
      coef = '{8'd14, 8'd11, 8'd13, 8'd9};
      r = '0;
      for (int c = 0; c < 4; c++)
         for (int i = 0; i < 4; i++) begin
            logic [7:0] acc;
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(coef[(j - i + 4) % 4], 8'(s >> (120 - 8 * (4 * c + j))));
            r = r | (128'(acc) << (120 - 8 * (4 * c + i)));
         end
      return r;
   endfunction

   task automatic expand_model(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = 32'(key >> (96 - 32 * i));
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_tab[tmp[31:24]], sbox_tab[tmp[23:16]],
                   sbox_tab[tmp[15:8]], sbox_tab[tmp[7:0]]} ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) begin
         raw_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
`ifdef AES_EQUIV_INV_KEY_EN
         exp_keys[r] = (r == 0 || r == 10) ? raw_keys[r] : inv_mix_model(raw_keys[r]);
`else
         exp_keys[r] = raw_keys[r];
`endif
      end
   endtask

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_key(input string tag, input logic [127:0] exp);
      checks++;
      assert (kif.round_key === exp) else begin
         errors++;
         $error("FAIL %s round_key observed %h expected %h", tag, kif.round_key, exp);
      end
   endtask

   task automatic check(input string tag, input logic [127:0] k, input logic [3:0] n,
                        input logic rdy, input logic bsy);
      check_key(tag, k);
      checks++;
      assert (kif.round_number === n) else begin
         errors++;
         $error("FAIL %s round_number observed %0d expected %0d", tag, kif.round_number, n);
      end
      checks++;
      assert (kif.key_ready === rdy) else begin
         errors++;
         $error("FAIL %s key_ready observed %b expected %b", tag, kif.key_ready, rdy);
      end
      checks++;
      assert (kif.busy === bsy) else begin
         errors++;
         $error("FAIL %s busy observed %b expected %b", tag, kif.busy, bsy);
      end
   endtask

   // Load a key (optionally colliding with next_key) and follow the expansion.
   task automatic load_and_expand(input logic [127:0] key, input logic nk_at_load);
      expand_model(key);
      kif.cipher_key = key;
      kif.key_load   = 1'b1;
      kif.next_key   = nk_at_load;
      tick();
      kif.key_load   = 1'b0;
      kif.cipher_key = rand128();
      check("load", exp_keys[0], 4'd0, 1'b0, 1'b1);
      for (int k = 1; k <= 10; k++) begin
         kif.next_key = 1'($urandom_range(0, 1));
         tick();
         if (k < 10) check("expand", exp_keys[k], 4'(k), 1'b0, 1'b1);
         else        check("ready10", exp_keys[10], 4'd10, 1'b1, 1'b0);
      end
      kif.next_key = 1'b0;
   endtask

   // Random next_key pattern in READY, tracking the expected round index.
   task automatic random_walk(input int cycles, inout int m);
      for (int c = 0; c < cycles; c++) begin
         logic nk;
         nk = 1'($urandom_range(0, 1));
         kif.next_key = nk;
         tick();
         if (nk) m = (m == 0) ? 10 : m - 1;
         check("walk", exp_keys[m], 4'(m), 1'b1, 1'b0);
      end
      kif.next_key = 1'b0;
   endtask

   initial begin
      int m;
      build_sbox();

      // Reset with random inputs
      rst = 1'b1;
      kif.cipher_key = rand128();
      kif.key_load   = 1'($urandom_range(0, 1));
      kif.next_key   = 1'($urandom_range(0, 1));
      tick(); tick(); tick();
      check("reset", 128'h0, 4'd0, 1'b0, 1'b0);
      rst = 1'b0;
      kif.key_load = 1'b0;
      kif.next_key = 1'b1;
      tick();
      check("idle", 128'h0, 4'd0, 1'b0, 1'b0);
      kif.next_key = 1'b0;

      // Known-answer key: back-to-back descent then wrap
      load_and_expand(128'h00112233445566778899aabbccddeeff, 1'b0);
      check_key("kat_r10", 128'h36d024461d84b8375fc0f9c04cbab6bb);
      kif.next_key = 1'b1;
      tick();
      check("kat_desc", exp_keys[9], 4'd9, 1'b1, 1'b0);
`ifndef AES_EQUIV_INV_KEY_EN
      check_key("kat_r9", 128'hda54053b2b549c71424441f7137a4f7b);
`else
      check_key("kat_r9", inv_mix_model(128'hda54053b2b549c71424441f7137a4f7b));
`endif
      for (int r = 8; r >= 0; r--) begin
         tick();
         check("kat_desc", exp_keys[r], 4'(r), 1'b1, 1'b0);
      end
      check_key("kat_r0", 128'h00112233445566778899aabbccddeeff);
      tick();
      check("wrap", exp_keys[10], 4'd10, 1'b1, 1'b0);
      check_key("wrap_r10", 128'h36d024461d84b8375fc0f9c04cbab6bb);
      kif.next_key = 1'b0;
      tick();
      check("hold", exp_keys[10], 4'd10, 1'b1, 1'b0);

      // FIPS-197 key
      load_and_expand(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
      check_key("fips_r10", 128'h13111d7fe3944a17f307a78b4d2b30c5);
      kif.next_key = 1'b1;
      for (int r = 9; r >= 0; r--) begin
         tick();
         check("fips_desc", exp_keys[r], 4'(r), 1'b1, 1'b0);
      end
      kif.next_key = 1'b0;

      // Random keys with random request gaps, wrap included
      for (int n = 0; n < 3; n++) begin
         load_and_expand(rand128(), 1'b0);
         m = 10;
         random_walk(30, m);
      end

      // key_load colliding with next_key mid-READY: load wins
      load_and_expand(rand128(), 1'b0);
      m = 10;
      random_walk(5, m);
      load_and_expand(rand128(), 1'b1);
      m = 10;
      random_walk(12, m);

      // Reset during expansion
      expand_model(rand128());
      kif.cipher_key = raw_keys[0];
      kif.key_load   = 1'b1;
      tick();
      kif.key_load   = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         check("pre_rst", exp_keys[k], 4'(k), 1'b0, 1'b1);
      end
      rst = 1'b1;
      tick();
      check("mid_rst", 128'h0, 4'd0, 1'b0, 1'b0);
      rst = 1'b0;
      kif.next_key = 1'b1;
      tick();
      check("post_rst", 128'h0, 4'd0, 1'b0, 1'b0);
      kif.next_key = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Absolute guard against a hang
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/aes_dec_keygen.md
# aes_dec_keygen

Sequential AES-128 key scheduler for the decryption datapath. It expands a cipher key forward to the round-10 key, one round per cycle. It then delivers round keys in descending order (10 down to 0), one per request, by running the inverse key schedule. It sits beside `keygen` and feeds the inverse-cipher round logic.

## Interface
Parameters: none.

Ports:
- `clk`  input  1  system clock; all state updates on rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `cipher_key`  input  128  AES-128 key, word 0 in bits [127:96]; sampled only when `key_load`=1.
- `key_load`  input  1  one-cycle strobe; starts a new expansion.
- `next_key`  input  1  advance to the next lower round key; honoured only when `key_ready`=1.
- `round_key`  output  128  current round key, valid while `key_ready`=1.
- `round_number`  output  4  round index of `round_key` (0..10).
- `key_ready`  output  1  expansion complete; `round_key`/`round_number` valid.
- `busy`  output  1  forward expansion in progress.

## Operation
- States: IDLE, EXPAND, READY.
- Registers: `work` (128b), `last` (128b, saved round-10 key), `rnd` (4b), state.
- Four `sbox` instances act on the last word of `work` (forward) or on w[i+3] of the newer key (inverse).
- Rcon for round r (1..10): 01,02,04,08,10,20,40,80,1b,36.
- Forward step r→r+1:
  - t = SubWord(RotWord(w3)) ^ {rcon[r+1],24'h0}
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
- Inverse step r→r-1, from key (v0..v3):
  - w3=v3^v2, w2=v2^v1, w1=v1^v0
  - w0=v0^SubWord(RotWord(w3))^{rcon[r],24'h0}.
- IDLE: `key_load` → `work`=`cipher_key`, `rnd`=0, go to EXPAND.
- EXPAND: one forward step per cycle, `rnd`++.
  - When `rnd` becomes 10, copy the new key into `last` too and go to READY.
  - `next_key` is ignored.
- READY: on `next_key`:
  - If `rnd`>0: inverse step, `rnd`--.
  - If `rnd`=0: wrap. `work`=`last`, `rnd`=10, for the next block, with no re-expansion.
- `key_load` in any state restarts from IDLE behaviour in that same cycle. `key_load` wins over a simultaneous `next_key`.
- `round_key` = `work` (or its transform, see Configuration). `round_number` = `rnd`. `key_ready` = (state==READY). `busy` = (state==EXPAND).
- All bytes are treated as GF(2^8) elements; XOR only, no carries.

## Timing
- Reset values: state IDLE, `work`=0, `last`=0, `rnd`=0. Outputs: `round_key`=0, `round_number`=0, `key_ready`=0, `busy`=0.
- `rst` mid-EXPAND or mid-READY aborts immediately. Outputs take reset values after that edge.
- `key_load` sampled at edge N:
  - `busy`=1 from N to N+10.
  - At edge N+10: `key_ready`=1, `round_number`=10, `round_key`=round-10 key.
  - Expansion latency is exactly 10 cycles.
- `key_load` while READY: `key_ready` drops after the same edge.
- `next_key` in READY: the new key and `round_number` appear after the sampling edge (1-cycle latency). Back-to-back `next_key` gives one key per cycle.
- Outputs are registered values, except the optional Configuration transform, which is combinational from `work`.

## Configuration
- `AES_EQUIV_INV_KEY_EN` defined: for `round_number` 1..9, `round_key` = InvMixColumns(`work`), for the equivalent inverse cipher. Rounds 0 and 10 are output raw. Internal schedule is unaffected.
- Not defined: `round_key` = `work` for all rounds; no InvMixColumns logic is built.

## Test plan
- Reset: assert `rst` with random inputs → all outputs 0, `busy`=0, `key_ready`=0.
- Basic expansion:
  - Stimulus: `cipher_key`=00112233445566778899aabbccddeeff with `key_load`.
  - After 10 cycles: `key_ready`=1, `round_number`=10, `round_key`=36d024461d84b8375fc0f9c04cbab6bb.
  - Next `next_key`: round 9 = da54053b2b549c71424441f7137a4f7b.
  - 10 consecutive `next_key`: round 0 = 00112233445566778899aabbccddeeff.
- FIPS-197 key: `cipher_key`=000102030405060708090a0b0c0d0e0f → round 10 = 13111d7fe3944a17f307a78b4d2b30c5. All 11 keys match the software model in descending order.
- Wrap: at round 0, `next_key` → next cycle `round_number`=10, round key identical to the first pass, `busy` stays 0.
- Restart and collision:
  - `key_load` with simultaneous `next_key` mid-READY → load wins; `key_ready`=0 for 10 cycles, then the new key's round-10 key.
  - `rst` at EXPAND cycle 5 → outputs 0 next cycle.
- `AES_EQUIV_INV_KEY_EN` build: rounds 0 and 10 equal the raw values above; rounds 1..9 equal InvMixColumns of the raw keys per the model. Without the macro, all rounds are raw.
